sample_uart_tx: RTL
===================

// Module: sample_uart_tx
// PURPOSE
//  Transmit-side stage after sample capture. Accepts one parallel logic-analyzer sample per
//  valid/ready handshake and sends it on a UART line, LSB byte first, 8N1 frames.
//  Owns its own bit timing; drives the physical TX pin toward the host.
// PARAMETERS
//  SAMPLE_BITS   16   sample width; multiple of 8, >= 8; BYTES = SAMPLE_BITS/8
//  CLKS_PER_BIT  868  i_clk cycles per UART bit; >= 2
// PORTS
//  i_clk      in   1            single clock, all logic on posedge
//  i_rst_n    in   1            synchronous reset, active-low
//  i_sample   in   SAMPLE_BITS  sample to send; captured on handshake
//  i_valid    in   1            sample available
//  o_ready    out  1            block can accept a sample (registered)
//  o_tx       out  1            UART line, idle high (registered)
//  o_busy     out  1            frame sequence in progress (registered)
// BEHAVIOUR
//  - Reset (i_rst_n=0 at posedge): state IDLE, o_tx=1, o_ready=1, o_busy=0, counters 0.
//    Reset mid-frame aborts at once: o_tx=1 at that edge, held sample discarded.
//  - Handshake: i_valid && o_ready at posedge N -> sample latched, o_ready=0, o_busy=1.
//    Start bit (o_tx=0) visible from edge N+1. i_valid while o_ready=0 is ignored.
//  - FSM: IDLE -> START -> DATA(8 bits, LSB first) -> [PARITY] -> STOP -> (next byte: START | last: IDLE).
//    Each state held exactly CLKS_PER_BIT cycles; baud counter restarts at 0 on every bit.
//  - Byte k (k=0..BYTES-1) = i_sample[8k+7:8k]; byte index and bit index counters wrap to 0.
//  - STOP: o_tx=1 for one bit. Consecutive bytes of one sample have no gap.
//  - Leaving last STOP -> IDLE: o_ready=1, o_busy=0, o_tx=1. If i_valid is high then,
//    the next sample is accepted that cycle; its start bit follows one cycle later
//    (exactly one idle-high cycle between samples).
//  - Sample duration: BYTES*FRAME*CLKS_PER_BIT cycles, FRAME = 10 (11 with parity).
//  - Baud counter width $clog2(CLKS_PER_BIT); no overflow beyond CLKS_PER_BIT-1.
// CONFIGURATION
//  SAMPLE_UART_PARITY_EN defined: PARITY state after DATA, o_tx = ^byte (even parity),
//   FRAME=11. Undefined: no PARITY state, DATA goes directly to STOP, FRAME=10.
// STRUCTURE
//  Package sample_uart_pkg: state encoding constants (ST_IDLE..ST_STOP), frame length
//   constants (DATA_BITS=8, FRAME_BITS). Sub-module baud_tick_gen (CLKS_PER_BIT param,
//   i_clk, i_rst_n, i_restart, o_tick) produces the end-of-bit tick; FSM and data
//   shifting stay in sample_uart_tx.
// TESTING (CLKS_PER_BIT=4, SAMPLE_BITS=16)
//  1 Reset held 3 cycles mid-transmission -> o_tx=1, o_ready=1, o_busy=0 at next edge; no further start bit.
//  2 Send 0xA53C -> line shows 0,0x3C LSB-first,1 then 0,0xA5,1; each bit 4 cycles; total 80 cycles.
//  3 i_valid held with 0x1234 then 0x5678 -> second start bit exactly 1 cycle after first sample's last stop bit.
//  4 i_valid pulses with 0xFFFF during busy -> ignored; transmitted data unchanged, o_ready stays 0.
//  5 PARITY_EN, send 0x0107 -> parity bits 1 (0x07) and 1 (0x01); total 88 cycles.
//  6 Idle, i_valid=0 for 100 cycles -> o_tx constant 1, o_ready constant 1.

Source files
------------

// File: rtl/sample_uart_pkg.sv
// Shared definitions for the sample UART transmitter: FSM state encoding,
// frame length constants and the parity helper. Optional macro: SAMPLE_UART_PARITY_EN.
package sample_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int DATA_BITS = 8;

`ifdef SAMPLE_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sample_uart_baud.sv
// Baud tick generator: counts CLKS_PER_BIT cycles per UART bit.
// Ports: i_clk, i_rst_n (sync, active-low), i_restart (hold count at 0), o_tick (last cycle of bit).
module baud_tick_gen
    import sample_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_tick = (cnt == LAST);

endmodule

// File: rtl/sample_uart_tx.sv
// Sends one SAMPLE_BITS-wide sample per valid/ready handshake as 8N1 UART frames,
// LSB byte first. Ports: i_clk, i_rst_n (sync, active-low), i_sample, i_valid,
// o_ready, o_tx (idle high), o_busy. Optional macro SAMPLE_UART_PARITY_EN adds even parity.
module sample_uart_tx
    import sample_uart_pkg::*;
#(
    parameter int SAMPLE_BITS  = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [SAMPLE_BITS-1:0] i_sample,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic                   o_tx,
    output logic                   o_busy
);

    localparam int BYTES = SAMPLE_BITS / 8;
    localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BYTES - 1);
    localparam logic [2:0]      LAST_BIT  = 3'(DATA_BITS - 1);

    state_t                 state;
    logic [SAMPLE_BITS-1:0] sample_q;
    logic [2:0]             bit_idx;
    logic [BI_W-1:0]        byte_idx;
    logic                   tick;
    logic [7:0]             cur_byte;

    // The byte on the wire is always the low byte; later bytes shift down.
    assign cur_byte = sample_q[7:0];

    // Counter is held at 0 while idle so START begins a full bit period.
    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_restart(state == ST_IDLE),
        .o_tick   (tick)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            o_tx     <= 1'b1;
            o_ready  <= 1'b1;
            o_busy   <= 1'b0;
            sample_q <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (i_valid && o_ready) begin
                        sample_q <= i_sample;
                        o_ready  <= 1'b0;
                        o_busy   <= 1'b1;
                        o_tx     <= 1'b0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        o_tx  <= cur_byte[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
`ifdef SAMPLE_UART_PARITY_EN
                            o_tx  <= even_parity(cur_byte);
                            state <= ST_PARITY;
`else
                            o_tx  <= 1'b1;
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            o_tx    <= cur_byte[bit_idx + 3'd1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        o_tx  <= 1'b1;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (byte_idx == LAST_BYTE) begin
                            byte_idx <= '0;
                            o_ready  <= 1'b1;
                            o_busy   <= 1'b0;
                            o_tx     <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            byte_idx <= byte_idx + BI_W'(1);
                            sample_q <= sample_q >> 8;
                            o_tx     <= 1'b0;
                            state    <= ST_START;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
